memsys_mp_ram: RTL

N-port AXI-lite data memory for the memory system: `NUM_PORTS` independent AXI-lite slave channels share one single-port BRAM through a round-robin arbiter. It generalises the fixed core/host dual-port DMEM to any number of requesters (cores, host, DMA), with configurable width and depth. Optional per-port statistics counters can be compiled in. It sits between the core/host interconnect and the BRAM, on the core clock.

---
 rtl/memsys_pkg.sv | 24 ++
 rtl/memsys_rr_arb.sv | 57 +++++
 rtl/memsys_mp_ram.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/memsys_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memsys_pkg
// Description : Shared types and constants for the multi-port data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package memsys_pkg;

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_PEND  = 2'd1,
        SLOT_RESP  = 2'd2
    } slot_state_t;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam int         DEF_STAT_W = 32;

    // Lowest byte-address bit that forms the word index.
    function automatic int word_lsb(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/memsys_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : memsys_rr_arb
// Description : Round-robin arbiter, one-hot grant, search starts after the
//               last granted requester.
// Revision    : 1.0 - initial release
// ============================================================================
module memsys_rr_arb #(
    parameter int NUM_PORTS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] i_req,
    output logic [NUM_PORTS-1:0] o_gnt
);

    localparam int c_IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int c_SUM_W = c_IDX_W + 1;
    localparam logic [c_SUM_W-1:0] c_NUM  = c_SUM_W'(NUM_PORTS);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(NUM_PORTS - 1);

    logic [c_IDX_W-1:0] r_ptr;
    logic [c_SUM_W-1:0] w_sum;
    logic [c_IDX_W-1:0] w_cand;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_found;

    always_comb begin
        o_gnt   = '0;
        w_sum   = '0;
        w_cand  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_sum = {1'b0, r_ptr} + c_SUM_W'(i);
            if (w_sum >= c_NUM) begin
                w_sum = w_sum - c_NUM;
            end
            w_cand = w_sum[c_IDX_W-1:0];
            if (!w_found && i_req[w_cand]) begin
                w_found       = 1'b1;
                w_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= (w_idx == c_LAST) ? '0 : w_idx + c_IDX_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/memsys_mp_ram.sv
`default_nettype none
// ============================================================================
// Module      : memsys_mp_ram
// Description : N-port AXI-lite data memory sharing one single-port BRAM via
//               a round-robin arbiter. Define MEMSYS_STATS_EN to build the
//               per-port grant/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module memsys_mp_ram
    import memsys_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 15,
    parameter int STAT_W    = DEF_STAT_W
) (
    input  logic                            core_clk,
    input  logic                            core_rst,
    input  logic [NUM_PORTS*ADDR_W-1:0]     s_awaddr,
    input  logic [NUM_PORTS-1:0]            s_awvalid,
    output logic [NUM_PORTS-1:0]            s_awready,
    input  logic [NUM_PORTS*DATA_W-1:0]     s_wdata,
    input  logic [NUM_PORTS*(DATA_W/8)-1:0] s_wstrb,
    input  logic [NUM_PORTS-1:0]            s_wvalid,
    output logic [NUM_PORTS-1:0]            s_wready,
    output logic [NUM_PORTS*2-1:0]          s_bresp,
    output logic [NUM_PORTS-1:0]            s_bvalid,
    input  logic [NUM_PORTS-1:0]            s_bready,
    input  logic [NUM_PORTS*ADDR_W-1:0]     s_araddr,
    input  logic [NUM_PORTS-1:0]            s_arvalid,
    output logic [NUM_PORTS-1:0]            s_arready,
    output logic [NUM_PORTS*DATA_W-1:0]     s_rdata,
    output logic [NUM_PORTS*2-1:0]          s_rresp,
    output logic [NUM_PORTS-1:0]            s_rvalid,
    input  logic [NUM_PORTS-1:0]            s_rready,
    output logic [NUM_PORTS*STAT_W-1:0]     stat_grant,
    output logic [NUM_PORTS*STAT_W-1:0]     stat_stall
);

    localparam int c_STRB_W = DATA_W / 8;
    localparam int c_LSB    = word_lsb(DATA_W);
    localparam int c_IDX_W  = ADDR_W - c_LSB;
    localparam int c_DEPTH  = 1 << c_IDX_W;

    logic                          r_run;
    logic [NUM_PORTS-1:0]          w_wr_pend;
    logic [NUM_PORTS-1:0]          w_rd_pend;
    logic [NUM_PORTS-1:0]          w_sel_wr;
    logic [NUM_PORTS-1:0]          w_req;
    logic [NUM_PORTS-1:0]          w_gnt;
    logic [NUM_PORTS-1:0]          w_unused_lsb;
    logic [NUM_PORTS*c_IDX_W-1:0]  w_widx_all;
    logic [NUM_PORTS*c_IDX_W-1:0]  w_ridx_all;
    logic [NUM_PORTS*DATA_W-1:0]   w_wdata_all;
    logic [NUM_PORTS*c_STRB_W-1:0] w_wstrb_all;

    logic                  w_op_vld;
    logic                  w_op_wr;
    logic [c_IDX_W-1:0]    w_op_idx;
    logic [DATA_W-1:0]     w_op_wdata;
    logic [c_STRB_W-1:0]   w_op_strb;
    logic [DATA_W-1:0]     r_mem [c_DEPTH];
    logic [DATA_W-1:0]     r_bram_q;

    // Holds all ready outputs low until the first edge after reset release.
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    assign w_req = w_wr_pend | w_rd_pend;

    memsys_rr_arb #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .clk   (core_clk),
        .rst   (core_rst),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_op_vld   = |w_gnt;
        w_op_wr    = 1'b0;
        w_op_idx   = '0;
        w_op_wdata = '0;
        w_op_strb  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_gnt[p]) begin
                w_op_wr    = w_sel_wr[p];
                w_op_idx   = w_sel_wr[p] ? w_widx_all[p*c_IDX_W +: c_IDX_W]
                                         : w_ridx_all[p*c_IDX_W +: c_IDX_W];
                w_op_wdata = w_wdata_all[p*DATA_W +: DATA_W];
                w_op_strb  = w_wstrb_all[p*c_STRB_W +: c_STRB_W];
            end
        end
    end

    // Single-port BRAM; contents deliberately survive reset.
    always_ff @(posedge core_clk) begin
        if (w_op_vld) begin
            if (w_op_wr) begin
                for (int b = 0; b < c_STRB_W; b++) begin
                    if (w_op_strb[b]) begin
                        r_mem[w_op_idx][b*8 +: 8] <= w_op_wdata[b*8 +: 8];
                    end
                end
            end else begin
                r_bram_q <= r_mem[w_op_idx];
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        slot_state_t         r_wst;
        slot_state_t         w_wst_nxt;
        slot_state_t         r_rdst;
        slot_state_t         w_rdst_nxt;
        logic                w_wr_acc;
        logic                w_rd_acc;
        logic                w_wr_gnt;
        logic                w_rd_gnt;
        logic                r_pref_rd;
        logic                r_rd_fresh;
        logic [c_IDX_W-1:0]  r_widx;
        logic [c_IDX_W-1:0]  r_ridx;
        logic [DATA_W-1:0]   r_wdata;
        logic [c_STRB_W-1:0] r_wstrb;
        logic [DATA_W-1:0]   r_rdata_hold;

        assign s_awready[p] = r_run && (r_wst == SLOT_EMPTY);
        assign s_wready[p]  = s_awready[p];
        assign s_arready[p] = r_run && (r_rdst == SLOT_EMPTY);
        assign w_wr_acc     = s_awready[p] && s_awvalid[p] && s_wvalid[p];
        assign w_rd_acc     = s_arready[p] && s_arvalid[p];

        assign w_wr_pend[p] = (r_wst == SLOT_PEND);
        assign w_rd_pend[p] = (r_rdst == SLOT_PEND);
        assign w_sel_wr[p]  = w_wr_pend[p] && !(w_rd_pend[p] && r_pref_rd);
        assign w_wr_gnt     = w_gnt[p] && w_sel_wr[p];
        assign w_rd_gnt     = w_gnt[p] && !w_sel_wr[p];

        assign s_bvalid[p]        = (r_wst == SLOT_RESP);
        assign s_rvalid[p]        = (r_rdst == SLOT_RESP);
        assign s_bresp[p*2 +: 2]  = RESP_OKAY;
        assign s_rresp[p*2 +: 2]  = RESP_OKAY;
        // BRAM output is live only the cycle after this port's read; then held.
        assign s_rdata[p*DATA_W +: DATA_W] = r_rd_fresh ? r_bram_q : r_rdata_hold;

        assign w_widx_all[p*c_IDX_W +: c_IDX_W]    = r_widx;
        assign w_ridx_all[p*c_IDX_W +: c_IDX_W]    = r_ridx;
        assign w_wdata_all[p*DATA_W +: DATA_W]     = r_wdata;
        assign w_wstrb_all[p*c_STRB_W +: c_STRB_W] = r_wstrb;
        assign w_unused_lsb[p] = ^{s_awaddr[p*ADDR_W +: c_LSB], s_araddr[p*ADDR_W +: c_LSB]};

        always_ff @(posedge core_clk or posedge core_rst) begin
            if (core_rst) begin
                r_wst  <= SLOT_EMPTY;
                r_rdst <= SLOT_EMPTY;
            end else begin
                r_wst  <= w_wst_nxt;
                r_rdst <= w_rdst_nxt;
            end
        end

        always_comb begin
            w_wst_nxt  = r_wst;
            w_rdst_nxt = r_rdst;
            case (r_wst)
                SLOT_EMPTY: if (w_wr_acc)     w_wst_nxt = SLOT_PEND;
                SLOT_PEND:  if (w_wr_gnt)     w_wst_nxt = SLOT_RESP;
                SLOT_RESP:  if (s_bready[p])  w_wst_nxt = SLOT_EMPTY;
                default:                      w_wst_nxt = SLOT_EMPTY;
            endcase
            case (r_rdst)
                SLOT_EMPTY: if (w_rd_acc)     w_rdst_nxt = SLOT_PEND;
                SLOT_PEND:  if (w_rd_gnt)     w_rdst_nxt = SLOT_RESP;
                SLOT_RESP:  if (s_rready[p])  w_rdst_nxt = SLOT_EMPTY;
                default:                      w_rdst_nxt = SLOT_EMPTY;
            endcase
        end

        always_ff @(posedge core_clk or posedge core_rst) begin
            if (core_rst) begin
                r_widx       <= '0;
                r_ridx       <= '0;
                r_wdata      <= '0;
                r_wstrb      <= '0;
                r_pref_rd    <= 1'b0;
                r_rd_fresh   <= 1'b0;
                r_rdata_hold <= '0;
            end else begin
                if (w_wr_acc) begin
                    r_widx  <= s_awaddr[p*ADDR_W + c_LSB +: c_IDX_W];
                    r_wdata <= s_wdata[p*DATA_W +: DATA_W];
                    r_wstrb <= s_wstrb[p*c_STRB_W +: c_STRB_W];
                end
                if (w_rd_acc) begin
                    r_ridx <= s_araddr[p*ADDR_W + c_LSB +: c_IDX_W];
                end
                // Preference flips only on a contested choice, so the lone
                // follow-up grant does not undo the alternation.
                if (w_gnt[p] && w_wr_pend[p] && w_rd_pend[p]) begin
                    r_pref_rd <= ~r_pref_rd;
                end
                r_rd_fresh <= w_rd_gnt;
                if (r_rd_fresh) begin
                    r_rdata_hold <= r_bram_q;
                end
            end
        end

`ifdef MEMSYS_STATS_EN
        logic [STAT_W-1:0] r_stat_grant;
        logic [STAT_W-1:0] r_stat_stall;

        always_ff @(posedge core_clk or posedge core_rst) begin
            if (core_rst) begin
                r_stat_grant <= '0;
                r_stat_stall <= '0;
            end else begin
                if (w_gnt[p] && !(&r_stat_grant)) begin
                    r_stat_grant <= r_stat_grant + STAT_W'(1);
                end
                if (w_req[p] && !w_gnt[p] && !(&r_stat_stall)) begin
                    r_stat_stall <= r_stat_stall + STAT_W'(1);
                end
            end
        end

        assign stat_grant[p*STAT_W +: STAT_W] = r_stat_grant;
        assign stat_stall[p*STAT_W +: STAT_W] = r_stat_stall;
`else
        assign stat_grant[p*STAT_W +: STAT_W] = '0;
        assign stat_stall[p*STAT_W +: STAT_W] = '0;
`endif
    end

endmodule
`default_nettype wire
